mcp23s17_responder: RTL
=======================

# mcp23s17_responder

SPI slave that emulates a subset of the Microchip MCP23S17 16-bit I/O expander (IOCON.BANK=0 map), the responder side of the MCP23S17 joystick protocol. It is used in simulation and on-board loopback to stand in for the physical expander on the JS_* header. The physical SPI master drives it over cs/sck/mosi. It exposes two 8-bit ports to fabric logic and raises an interrupt-on-change.

## Interface
- HW_ADDR, 3'b000: hardware address A2..A0 matched against opcode bits [3:1] when IOCON.HAEN=1.
- clk  in  1  system clock (28 MHz); all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  SPI chip select, active low, asynchronous to clk.
- sck  in  1  SPI clock, mode 0, asynchronous to clk.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- miso_oe  out  1  high while miso is actively driven (read data phase).
- inta  out  1  interrupt, active low.
- gpa_in, gpb_in  in  8  external pin levels, asynchronous.
- gpa_out, gpb_out  out  8  OLATA/OLATB contents.
- gpa_dir, gpb_dir  out  8  IODIRA/IODIRB contents (1 = input).

## Operation
- cs, sck, mosi, gpa_in and gpb_in pass through 2-FF synchronizers. Edges are detected on the synchronized cs and sck.
- Frame: cs falling edge resets the bit counter. Byte 0 is the opcode 0100_A2A1A0_RW. Byte 1 is the register address. Bytes 2+ are data. The frame ends on cs rising edge; a partial byte is discarded.
- Opcode match: bits [7:4]=4'b0100. If HAEN=1, bits [3:1] must also equal HW_ADDR. On mismatch the frame is ignored: no writes, miso_oe stays 0.
- States: IDLE, OPCODE, ADDR, WRITE, READ, IGNORE.
  - cs fall: any state -> OPCODE.
  - cs rise: any state -> IDLE.
  - 8th bit in OPCODE: -> ADDR on match, otherwise -> IGNORE.
  - 8th bit in ADDR: -> READ if RW=1, otherwise -> WRITE.
- Register map, with reset values:
  - 0x00/0x01 IODIRA/B (FF).
  - 0x02/0x03 IPOLA/B (00).
  - 0x04/0x05 GPINTENA/B (00).
  - 0x0A and 0x0B both access IOCON (00). Bit 6 is MIRROR, bit 5 is SEQOP, bit 3 is HAEN. Other bits are stored but have no effect.
  - 0x0C/0x0D GPPUA/B (00), stored only.
  - 0x0E/0x0F INTFA/B (00), read-only.
  - 0x10/0x11 INTCAPA/B (00), read-only.
  - 0x12/0x13 GPIOA/B. A read returns the synchronized pins XOR IPOL. A write updates OLAT.
  - 0x14/0x15 OLATA/B (00).
  - 0x06-0x09 and 0x16-0xFF read 0x00; writes to them are ignored.
- Address pointer: after each data byte, it increments when SEQOP=0 and is held when SEQOP=1. It wraps from 0x15 to 0x00. Addresses above 0x15 increment without wrap and keep reading 0x00.
- WRITE: on the 8th data bit, the shift register is written to reg[ptr], then the pointer advances.
- READ: the MISO shift register loads reg[ptr] when the 8th bit of the previous byte (ADDR or prior data) is sampled. miso_oe rises at that load. miso shifts on each sck falling edge. The next load uses the advanced pointer.
- Interrupt, per port:
  - A change is a synchronized pin differing from its previous-cycle value on a bit with GPINTEN=1.
  - If INTF of that port is 0, INTF is set to the changed-and-enabled bits and INTCAP captures the current pin value.
  - While INTF≠0, further changes are ignored.
  - Reading GPIO or INTCAP of the port clears its INTF at load time.
  - A new change in the same cycle as the clear wins: INTF is set again.
- inta is low when INTFA≠0. If MIRROR=1, inta is low when INTFA≠0 or INTFB≠0. INTB is not provided.

## Timing
- Reset values: miso=0, miso_oe=0, inta=1, gpa_out=gpb_out=00, gpa_dir=gpb_dir=FF, all registers as listed above, FSM=IDLE.
- Supported sck is at most clk/8 (3.5 MHz), with each sck phase at least 4 clk.
- cs low to first sck rise: at least 4 clk. Last sck fall to cs high: at least 4 clk.
- Write latency: the register and output ports update 3 clk after the 8th raw sck rising edge (2 sync + 1 detect).
- miso: valid at most 3 clk after the raw sck falling edge, or after the 16th raw rising edge for the first data bit.
- miso_oe returns to 0 at most 3 clk after raw cs rise.
- Pin-change to inta low: 4 clk.
- rst mid-frame aborts the frame with no partial write. Bytes until the next cs falling edge are ignored.

## Test plan
- Reset: assert rst -> inta=1, miso_oe=0, gpa_dir=FF, gpa_out=00. A read of 0x00 returns FF and of 0x0A returns 00.
- Sequential write: 40 14 A5 3C -> gpa_out=A5, gpb_out=3C. Then read 41 14 xx xx -> miso bytes A5, 3C, and miso_oe high only during the data bytes.
- SEQOP and wrap:
  - Write IOCON=20, then read 41 12 with gpa_in=5A -> every data byte is 5A.
  - With SEQOP=0, read 41 15 xx xx -> OLATB then IODIRA (FF).
- Address match: write IOCON=08 with HW_ADDR=3'b010. Then 40 14 FF -> gpa_out unchanged; 44 14 FF -> gpa_out=FF.
- Interrupt:
  - GPINTENA=01 and IPOLA=00; toggle gpa_in[0] 0->1 -> inta low after 4 clk and INTFA=01; read INTCAPA -> 01.
  - A further toggle before the read does not change INTCAPA.
  - After the read, inta=1.
- Abort: cs rise after 5 bits of a write data byte -> no register change. rst mid-read -> miso_oe=0 and the next frame works normally.

Source files
------------

// File: rtl/mcp23s17_responder.sv
// SPI-slave emulation of an MCP23S17 16-bit I/O expander (IOCON.BANK=0 map).
// All SPI and pin inputs are oversampled in the clk domain; INTA reflects port A (or A|B when mirrored).
module mcp23s17_responder #(
  parameter logic [2:0] HW_ADDR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       inta,
  input  logic [7:0] gpa_in,
  input  logic [7:0] gpb_in,
  output logic [7:0] gpa_out,
  output logic [7:0] gpb_out,
  output logic [7:0] gpa_dir,
  output logic [7:0] gpb_dir
);

  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, WRITE, READ, IGNORE} state_t;

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic [1:0][7:0] pin_meta_q, pin_sync_q, pin_prev_q;

  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] miso_sh_q, miso_sh_d;
  logic       miso_oe_q, miso_oe_d;
  logic       inta_q, inta_d;
  logic [1:0][7:0] iodir_q, iodir_d, ipol_q, ipol_d, gpinten_q, gpinten_d, gppu_q, gppu_d;
  logic [1:0][7:0] intf_q, intf_d, intcap_q, intcap_d, olat_q, olat_d;
  logic [7:0] iocon_q, iocon_d;

  logic cs_fall, cs_rise, sck_rise, sck_fall, byte_done, opcode_ok, load;
  logic [7:0] byte_in, ptr_next, rd_addr, rd_data;
  logic [1:0] clr;
  logic [1:0][7:0] change;

  // cs chain resets low so a reset taken mid-frame never fakes a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      pin_meta_q  <= '0;
      pin_sync_q  <= '0;
      pin_prev_q  <= '0;
    end else begin
      cs_meta_q   <= cs;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sck_meta_q  <= sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
      pin_meta_q  <= {gpb_in, gpa_in};
      pin_sync_q  <= pin_meta_q;
      pin_prev_q  <= pin_sync_q;
    end
  end

  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q & cs_sync_q;
  assign sck_rise  = ~cs_sync_q & sck_sync_q & ~sck_prev_q;
  assign sck_fall  = ~cs_sync_q & ~sck_sync_q & sck_prev_q;
  assign byte_in   = {shift_q, mosi_sync_q};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign opcode_ok = (byte_in[7:4] == 4'b0100) && (!iocon_q[3] || (byte_in[3:1] == HW_ADDR));
  assign ptr_next  = iocon_q[5] ? ptr_q : ((ptr_q == 8'h15) ? 8'h00 : ptr_q + 8'd1);
  assign rd_addr   = (state_q == ADDR) ? byte_in : ptr_next;
  assign change[0] = (pin_sync_q[0] ^ pin_prev_q[0]) & gpinten_q[0];
  assign change[1] = (pin_sync_q[1] ^ pin_prev_q[1]) & gpinten_q[1];

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      8'h00, 8'h01: rd_data = iodir_q[rd_addr[0]];
      8'h02, 8'h03: rd_data = ipol_q[rd_addr[0]];
      8'h04, 8'h05: rd_data = gpinten_q[rd_addr[0]];
      8'h0A, 8'h0B: rd_data = iocon_q;
      8'h0C, 8'h0D: rd_data = gppu_q[rd_addr[0]];
      8'h0E, 8'h0F: rd_data = intf_q[rd_addr[0]];
      8'h10, 8'h11: rd_data = intcap_q[rd_addr[0]];
      8'h12, 8'h13: rd_data = pin_sync_q[rd_addr[0]] ^ ipol_q[rd_addr[0]];
      8'h14, 8'h15: rd_data = olat_q[rd_addr[0]];
      default:      rd_data = 8'h00;
    endcase
  end

  // Frame sequencing, register writes and MISO byte loading.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    ptr_d     = ptr_q;
    miso_sh_d = miso_sh_q;
    miso_oe_d = miso_oe_q;
    iodir_d   = iodir_q;
    ipol_d    = ipol_q;
    gpinten_d = gpinten_q;
    gppu_d    = gppu_q;
    olat_d    = olat_q;
    iocon_d   = iocon_q;
    load      = 1'b0;
    if (cs_rise) begin
      state_d   = IDLE;
      miso_oe_d = 1'b0;
      miso_sh_d = 8'h00;
    end else if (cs_fall) begin
      state_d   = OPCODE;
      bit_cnt_d = 3'd0;
      miso_oe_d = 1'b0;
    end else if (state_q != IDLE) begin
      if (sck_rise) begin
        shift_d   = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      // The fall right after a byte load must keep the freshly loaded MSB on miso.
      if (sck_fall && (state_q == READ) && (bit_cnt_q != 3'd0))
        miso_sh_d = {miso_sh_q[6:0], 1'b0};
      if (byte_done) begin
        case (state_q)
          OPCODE: begin
            rw_d    = byte_in[0];
            state_d = opcode_ok ? ADDR : IGNORE;
          end
          ADDR: begin
            ptr_d   = byte_in;
            state_d = rw_q ? READ : WRITE;
            load    = rw_q;
          end
          WRITE: begin
            ptr_d = ptr_next;
            case (ptr_q)
              8'h00, 8'h01: iodir_d[ptr_q[0]]   = byte_in;
              8'h02, 8'h03: ipol_d[ptr_q[0]]    = byte_in;
              8'h04, 8'h05: gpinten_d[ptr_q[0]] = byte_in;
              8'h0A, 8'h0B: iocon_d             = byte_in;
              8'h0C, 8'h0D: gppu_d[ptr_q[0]]    = byte_in;
              8'h12, 8'h13, 8'h14, 8'h15: olat_d[ptr_q[0]] = byte_in;
              default: ;
            endcase
          end
          READ: begin
            ptr_d = ptr_next;
            load  = 1'b1;
          end
          default: ;
        endcase
      end
    end
    if (load) begin
      miso_sh_d = rd_data;
      miso_oe_d = 1'b1;
    end
  end

  // A change arriving in the same cycle as a read-clear re-arms INTF.
  always_comb begin
    clr[0]   = load && ((rd_addr == 8'h10) || (rd_addr == 8'h12));
    clr[1]   = load && ((rd_addr == 8'h11) || (rd_addr == 8'h13));
    intf_d   = intf_q;
    intcap_d = intcap_q;
    for (int p = 0; p < 2; p++) begin
      if (clr[p]) intf_d[p] = 8'h00;
      if ((intf_d[p] == 8'h00) && (change[p] != 8'h00)) begin
        intf_d[p]   = change[p];
        intcap_d[p] = pin_sync_q[p];
      end
    end
    inta_d = ~((intf_q[0] != 8'h00) || (iocon_q[6] && (intf_q[1] != 8'h00)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      rw_q      <= 1'b0;
      ptr_q     <= 8'h00;
      miso_sh_q <= 8'h00;
      miso_oe_q <= 1'b0;
      inta_q    <= 1'b1;
      iodir_q   <= {8'hFF, 8'hFF};
      ipol_q    <= '0;
      gpinten_q <= '0;
      gppu_q    <= '0;
      intf_q    <= '0;
      intcap_q  <= '0;
      olat_q    <= '0;
      iocon_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      ptr_q     <= ptr_d;
      miso_sh_q <= miso_sh_d;
      miso_oe_q <= miso_oe_d;
      inta_q    <= inta_d;
      iodir_q   <= iodir_d;
      ipol_q    <= ipol_d;
      gpinten_q <= gpinten_d;
      gppu_q    <= gppu_d;
      intf_q    <= intf_d;
      intcap_q  <= intcap_d;
      olat_q    <= olat_d;
      iocon_q   <= iocon_d;
    end
  end

  assign miso    = miso_sh_q[7];
  assign miso_oe = miso_oe_q;
  assign inta    = inta_q;
  assign gpa_out = olat_q[0];
  assign gpb_out = olat_q[1];
  assign gpa_dir = iodir_q[0];
  assign gpb_dir = iodir_q[1];

endmodule
